// File: rtl/sdf_r2_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sdf_r2_feeder_pkg
// Shared constants, types and helpers for the radix-2 SDF FFT stage feeder.
//   FFT_DATA_W : packed complex sample width ([23:12] real, [11:0] imag)
//   FFT_HALF_W : width of one real/imag half
//   FFT_N      : default transform length
//   FFT_LOG2_D : default log2 of the delay-line depth (D = FFT_N/2)
//   phase_e    : feeder phase (fill / compute), taken from the counter MSB
//   re/im/pack : split and assemble packed complex samples
// -----------------------------------------------------------------------------
package sdf_r2_feeder_pkg;

   localparam int FFT_DATA_W = 24;
   localparam int FFT_HALF_W = 12;
   localparam int FFT_N      = 1024;
   localparam int FFT_LOG2_D = 9;

   typedef enum logic {
      PH_FILL = 1'b0,
      PH_COMP = 1'b1
   } phase_e;

   function automatic logic [FFT_HALF_W-1:0] re(input logic [FFT_DATA_W-1:0] x);
      return x[FFT_DATA_W-1:FFT_HALF_W];
   endfunction

   function automatic logic [FFT_HALF_W-1:0] im(input logic [FFT_DATA_W-1:0] x);
      return x[FFT_HALF_W-1:0];
   endfunction

   function automatic logic [FFT_DATA_W-1:0] pack(input logic [FFT_HALF_W-1:0] r,
                                                  input logic [FFT_HALF_W-1:0] i);
      return {r, i};
   endfunction

endpackage

// File: rtl/sdf_r2_feeder_delay_line.sv
// -----------------------------------------------------------------------------
// sdf_r2_feeder_delay_line
// Single-address feedback memory of D = 2**LOG2_D words. The read is
// combinational from addr, so the word read this cycle is the old contents;
// the write lands on the same rising edge (read-old-then-write).
// Contents are deliberately not reset.
// Ports:
//   clk    in  1       rising-edge clock
//   addr   in  LOG2_D  shared read/write address
//   we     in  1       write enable
//   wdata  in  DATA_W  write data
//   rdata  out DATA_W  combinational read data at addr
// -----------------------------------------------------------------------------
module sdf_r2_feeder_delay_line #(
   parameter int DATA_W = 24,
   parameter int LOG2_D = 9
) (
   input  logic              clk,
   input  logic [LOG2_D-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**LOG2_D];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/sdf_r2_feeder.sv
// -----------------------------------------------------------------------------
// sdf_r2_feeder
// Radix-2 single-path delay-feedback feeder for one FFT stage. Samples k and
// k+D of each 2D-sample frame are presented to an external combinational
// butterfly as A/B. C1 goes straight to the output register; C2 is parked in
// the delay line and emitted during the following frame's fill phase.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   in_valid   in   1       in_data valid; counter and delay line advance only when high
//   in_data    in   DATA_W  input sample, natural order
//   bf_a       out  DATA_W  butterfly A (delayed sample), zero during fill
//   bf_b       out  DATA_W  butterfly B (current in_data), zero during fill
//   bf_c1      in   DATA_W  butterfly A+B, same cycle
//   bf_c2      in   DATA_W  butterfly A-B, same cycle
//   out_valid  out  1       out_data valid, registered
//   out_data   out  DATA_W  output sample, registered
//   out_first  out  1       first output of a frame (C1 of pair 0), registered
// -----------------------------------------------------------------------------
module sdf_r2_feeder
   import sdf_r2_feeder_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int LOG2_D = FFT_LOG2_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] bf_a,
   output logic [DATA_W-1:0] bf_b,
   input  logic [DATA_W-1:0] bf_c1,
   input  logic [DATA_W-1:0] bf_c2,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_first
);

   localparam logic [LOG2_D:0] CNT_MID  = (LOG2_D+1)'(2**LOG2_D);
   localparam logic [LOG2_D:0] CNT_LAST = {(LOG2_D+1){1'b1}};

   logic [LOG2_D:0]   cnt_q, cnt_d;
   logic              primed_q, primed_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_first_q, out_first_d;

   phase_e            phase;
   logic              dl_we;
   logic [DATA_W-1:0] dl_wdata;
   logic [DATA_W-1:0] dl_rdata;

   assign phase = phase_e'(cnt_q[LOG2_D]);

   sdf_r2_feeder_delay_line #(
      .DATA_W (DATA_W),
      .LOG2_D (LOG2_D)
   ) u_delay_line (
      .clk   (clk),
      .addr  (cnt_q[LOG2_D-1:0]),
      .we    (dl_we),
      .wdata (dl_wdata),
      .rdata (dl_rdata)
   );

   // Butterfly inputs are forced to zero during fill so the butterfly sees a
   // quiet operand pair when no pairing is possible.
   assign bf_a = (phase == PH_COMP) ? dl_rdata : '0;
   assign bf_b = (phase == PH_COMP) ? in_data  : '0;

   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_first_d = 1'b0;
      dl_we       = 1'b0;
      dl_wdata    = in_data;

      if (in_valid) begin
         // Natural wrap of the LOG2_D+1 bit counter gives 2D-1 -> 0.
         cnt_d       = cnt_q + 1'b1;
         dl_we       = 1'b1;
         out_first_d = (cnt_q == CNT_MID);
         if (cnt_q == CNT_LAST) begin
            primed_d = 1'b1;
         end

         if (phase == PH_COMP) begin
            out_valid_d = 1'b1;
            out_data_d  = bf_c1;
            dl_wdata    = bf_c2;
         end else begin
            // Fill phase drains the previous frame's C2 words; before the
            // first full frame the memory holds junk, so nothing is emitted
            // and out_data keeps its value.
            out_valid_d = primed_q;
            if (primed_q) begin
               out_data_d = dl_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_first_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_first_q <= out_first_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_first = out_first_q;

endmodule

// File: tb/tb_sdf_r2_feeder.sv
// -----------------------------------------------------------------------------
// tb_sdf_r2_feeder
// Directed and random stimulus for sdf_r2_feeder with LOG2_D=2 (D=4, 8-point
// frames). A wrapping per-half add/sub stub plays the butterfly. A reference
// model pushes expected outputs to a scoreboard as each sample is accepted;
// they are popped when the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_sdf_r2_feeder;
   import sdf_r2_feeder_pkg::*;

   localparam int LOG2_D = 2;
   localparam int D      = 2**LOG2_D;
   localparam int W      = FFT_DATA_W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic [W-1:0] bf_a, bf_b, bf_c1, bf_c2;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_first;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] cadd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [FFT_HALF_W-1:0] r, i;
      r = re(a) + re(b);
      i = im(a) + im(b);
      return pack(r, i);
   endfunction

   function automatic logic [W-1:0] csub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [FFT_HALF_W-1:0] r, i;
      r = re(a) - re(b);
      i = im(a) - im(b);
      return pack(r, i);
   endfunction

   function automatic logic [W-1:0] xn(input int n);
      logic [FFT_HALF_W-1:0] h;
      h = FFT_HALF_W'(n);
      return {h, h};
   endfunction

   assign bf_c1 = cadd(bf_a, bf_b);
   assign bf_c2 = csub(bf_a, bf_b);

   sdf_r2_feeder #(
      .DATA_W (W),
      .LOG2_D (LOG2_D)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .bf_a      (bf_a),
      .bf_b      (bf_b),
      .bf_c1     (bf_c1),
      .bf_c2     (bf_c2),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_first (out_first)
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic         first;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] got_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           n_first;

   // reference model state
   int           m_cnt;
   logic         m_primed;
   logic [W-1:0] m_x [D];
   logic [W-1:0] m_c2[D];
   logic [W-1:0] last_data;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk1({tag, "_ov"}, out_valid, 1'b0);
      chk ({tag, "_od"}, out_data, '0);
      chk1({tag, "_of"}, out_first, 1'b0);
      chk ({tag, "_bfa"}, bf_a, '0);
      chk ({tag, "_bfb"}, bf_b, '0);
   endtask

   task automatic do_reset(input int cycles);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      repeat (cycles) begin
         @(posedge clk); #1;
         check_idle_zero("rst");
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_idle_zero("post_rst");
      m_cnt     = 0;
      m_primed  = 1'b0;
      last_data = '0;
      n_first   = 0;
      sb.delete();
      got_q.delete();
   endtask

   // One clock: drive, check the combinational butterfly ports, update the
   // model, then check the registered outputs after the edge.
   task automatic step(input logic v, input logic [W-1:0] d);
      logic exp_v;
      exp_t e;
      int   k;
      in_valid = v;
      in_data  = d;
      #1;
      if (m_cnt >= D) begin
         chk("bf_a", bf_a, m_x[m_cnt-D]);
         chk("bf_b", bf_b, d);
      end else begin
         chk("bf_a_fill", bf_a, '0);
         chk("bf_b_fill", bf_b, '0);
      end
      exp_v = 1'b0;
      if (v) begin
         if (m_cnt < D) begin
            if (m_primed) begin
               exp_v = 1'b1;
               sb.push_back(exp_t'{data: m_c2[m_cnt], first: 1'b0});
            end
            m_x[m_cnt] = d;
         end else begin
            k     = m_cnt - D;
            exp_v = 1'b1;
            sb.push_back(exp_t'{data: cadd(m_x[k], d), first: (m_cnt == D)});
            m_c2[k] = csub(m_x[k], d);
         end
         if (m_cnt == 2*D-1) m_primed = 1'b1;
         m_cnt = (m_cnt + 1) % (2*D);
      end
      @(posedge clk); #1;
      chk1("out_valid", out_valid, exp_v);
      if (exp_v) begin
         e = sb.pop_front();
         if (out_valid) begin
            chk ("out_data", out_data, e.data);
            chk1("out_first", out_first, e.first);
         end
      end
      if (out_valid) begin
         last_data = out_data;
         got_q.push_back(out_data);
         if (out_first) n_first++;
      end else begin
         chk ("out_hold", out_data, last_data);
         chk1("out_first_idle", out_first, 1'b0);
      end
   endtask

   task automatic frame(input int base, input logic stall);
      for (int n = 0; n < 2*D; n++) begin
         step(1'b1, xn(base + n));
         if (stall) step(1'b0, W'($urandom));
      end
   endtask

   task automatic drain(input logic stall);
      for (int n = 0; n < D; n++) begin
         step(1'b1, '0);
         if (stall) step(1'b0, W'($urandom));
      end
   endtask

   task automatic check_t2(input string tag);
      logic [W-1:0] t2 [8];
      logic [W-1:0] g;
      t2 = '{24'h004004, 24'h006006, 24'h008008, 24'h00A00A,
             24'hFFCFFC, 24'hFFCFFC, 24'hFFCFFC, 24'hFFCFFC};
      chki({tag, "_count"}, got_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         chk({tag, "_seq"}, g, t2[i]);
      end
      chki({tag, "_firsts"}, n_first, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // 1. reset with in_valid held high
      do_reset(2);

      // 2. single frame plus drain
      frame(0, 1'b0);
      drain(1'b0);
      check_t2("t2");

      // 3. same with in_valid toggling
      do_reset(2);
      frame(0, 1'b1);
      drain(1'b1);
      check_t2("t3");

      // 4. back-to-back frames
      do_reset(2);
      frame(0, 1'b0);
      frame(8, 1'b0);
      drain(1'b0);
      chki("t4_count", got_q.size(), 16);
      for (int k = 0; k < D; k++) begin
         chk("t4_c1_f1", (8+k < got_q.size()) ? got_q[8+k] : 'x, xn(2*k + 20));
      end
      chki("t4_firsts", n_first, 2);

      // 5. reset after five samples, then a clean frame
      do_reset(2);
      for (int n = 0; n < 5; n++) step(1'b1, xn(n));
      do_reset(2);
      frame(0, 1'b0);
      drain(1'b0);
      check_t2("t5");

      // random samples and random stalls over three frames
      do_reset(2);
      for (int f = 0; f < 3; f++) begin
         int acc;
         acc = 0;
         while (acc < 2*D) begin
            if ($urandom_range(0, 2) != 0) begin
               step(1'b1, W'($urandom));
               acc++;
            end else begin
               step(1'b0, W'($urandom));
            end
         end
      end
      drain(1'b0);
      chki("rand_count", got_q.size(), 6*D);
      chki("rand_firsts", n_first, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
